// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // MULHSU treats rs1 as signed but rs2 as unsigned, hence two separate helpers.
  function automatic logic signedRs1(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signedRs2(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between decode + register file (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if #(parameter int XLEN = 32);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_addr,
    input  busy, done, we, rd_out, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_addr,
    output busy, done, we, rd_out, result
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per clock on unsigned magnitudes, with the sign fix applied on the last step.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_t            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              negRes_q, negRes_d;
  logic              negRem_q, negRem_d;
  logic [4:0]        rdOut_q, rdOut_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              signA, signB;
  logic [XLEN-1:0]   absA, absB;
  logic              divZero, divOvf;
  logic [XLEN-1:0]   accHi, accLo;
  logic              subMode;
  logic [XLEN:0]     addA, addB, sum;
  logic [2*XLEN-1:0] stepAcc;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient, remainder;
  logic [XLEN-1:0]   finalResult;

  // Operand conditioning on the accept edge: magnitudes plus the special cases
  // that finish without iterating.
  always_comb begin
    signA   = signedRs1(bus.funct3) & bus.rs1_val[XLEN-1];
    signB   = signedRs2(bus.funct3) & bus.rs2_val[XLEN-1];
    absA    = signA ? -bus.rs1_val : bus.rs1_val;
    absB    = signB ? -bus.rs2_val : bus.rs2_val;
    divZero = bus.funct3[2] && (bus.rs2_val == '0);
    divOvf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
              (bus.rs1_val == MIN_NEG) && (bus.rs2_val == ALL_ONES);
  end

  // One iteration through the shared adder. Multiply keeps the multiplier in the
  // low half and shifts right; divide keeps the dividend/quotient in the low half,
  // the partial remainder in the high half, and shifts left.
  always_comb begin
    accHi   = acc_q[2*XLEN-1:XLEN];
    accLo   = acc_q[XLEN-1:0];
    subMode = funct3_q[2];
    addA    = subMode ? {accHi, accLo[XLEN-1]} : {1'b0, accHi};
    if (subMode) begin
      addB = ~{1'b0, operand_q};
    end else begin
      addB = accLo[0] ? {1'b0, operand_q} : '0;
    end
    sum = addA + addB + {{XLEN{1'b0}}, subMode};
    if (!subMode) begin
      stepAcc = {sum, accLo[XLEN-1:1]};
    end else if (sum[XLEN]) begin
      stepAcc = {addA[XLEN-1:0], accLo[XLEN-2:0], 1'b0};
    end else begin
      stepAcc = {sum[XLEN-1:0], accLo[XLEN-2:0], 1'b1};
    end
  end

  // Sign fix on the outcome of the final step; the remainder follows the dividend.
  always_comb begin
    product     = negRes_q ? -stepAcc : stepAcc;
    quotient    = negRes_q ? -stepAcc[XLEN-1:0] : stepAcc[XLEN-1:0];
    remainder   = negRem_q ? -stepAcc[2*XLEN-1:XLEN] : stepAcc[2*XLEN-1:XLEN];
    finalResult = '0;
    unique case (funct3_q)
      F3_MUL:                       finalResult = product[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: finalResult = product[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              finalResult = quotient;
      F3_REM, F3_REMU:              finalResult = remainder;
      default:                      finalResult = '0;
    endcase
  end

  // Next-state and datapath load logic; start is only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    count_d   = count_q;
    funct3_d  = funct3_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    rdOut_d   = rdOut_q;
    result_d  = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          funct3_d  = bus.funct3;
          rdOut_d   = bus.rd_addr;
          negRes_d  = signA ^ signB;
          negRem_d  = signA;
          count_d   = '0;
          acc_d     = {{XLEN{1'b0}}, (bus.funct3[2] ? absA : absB)};
          operand_d = bus.funct3[2] ? absB : absA;
          if (divZero) begin
            result_d = bus.funct3[1] ? bus.rs1_val : ALL_ONES;
            state_d  = ST_FIN;
          end else if (divOvf) begin
            result_d = bus.funct3[1] ? '0 : MIN_NEG;
            state_d  = ST_FIN;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d   = stepAcc;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          result_d = finalResult;
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      operand_q <= '0;
      count_q   <= '0;
      funct3_q  <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      rdOut_q   <= '0;
      result_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      funct3_q  <= funct3_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      rdOut_q   <= rdOut_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_FIN);
  assign bus.we     = (state_q == ST_FIN) && (rdOut_q != 5'd0);
  assign bus.rd_out = rdOut_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push a model-computed expectation,
// and a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          startCycle;
    int          lat;
  } expect_t;

  logic    clk = 1'b0;
  logic    rst;
  int      cycle = 0;
  int      nVec = 0;
  int      nFail = 0;
  expect_t sbQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural reference built from 64-bit integer arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    q  = 0;
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
      F3_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; q = ua / ub; return q[31:0]; end
      F3_REM:    begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default:   begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    nVec++;
    if (actual !== required) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int holdCycles);
    int      waitCnt;
    expect_t e;
    waitCnt = 0;
    @(negedge clk);
    while (bus.busy && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.busy) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL issue-timeout: busy=1, expected 0 within 200 cycles");
      return;
    end
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    e.res        = refResult(f3, a, b);
    e.rd         = rd;
    e.we         = (rd != 5'd0);
    e.startCycle = cycle;
    e.lat        = refLatency(f3, a, b);
    sbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < holdCycles; i++) begin
      bus.funct3  = 3'($urandom);
      bus.rs1_val = $urandom;
      bus.rs2_val = $urandom;
      bus.rd_addr = 5'($urandom);
      @(negedge clk);
    end
    bus.start   = 1'b0;
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (!rst && bus.done) begin
      if (sbQ.size() == 0) begin
        nVec++;
        nFail++;
        $display("[TB] FAIL unexpected-done: done=1 with result 0x%08h, expected no completion",
                 bus.result);
      end else begin
        e = sbQ.pop_front();
        checkOutput("result", bus.result, e.res);
        checkOutput("rd_out", 32'(bus.rd_out), 32'(e.rd));
        checkOutput("we", 32'(bus.we), 32'(e.we));
        checkOutput("latency", 32'(cycle - e.startCycle), 32'(e.lat));
      end
    end
  end

  initial begin
    int waitCnt;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.funct3  = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset-busy", 32'(bus.busy), 32'd0);
    checkOutput("reset-done", 32'(bus.done), 32'd0);
    checkOutput("reset-we", 32'(bus.we), 32'd0);
    checkOutput("reset-rd_out", 32'(bus.rd_out), 32'd0);
    checkOutput("reset-result", bus.result, 32'd0);

    $display("[TB] directed operations");
    applyStimulus(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  0);
    applyStimulus(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  0);
    applyStimulus(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  0);
    applyStimulus(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  0);
    applyStimulus(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  0);
    applyStimulus(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 0);
    applyStimulus(F3_DIVU,   32'd100,        32'd7,         5'd11, 0);
    applyStimulus(F3_REMU,   32'd100,        32'd7,         5'd12, 0);

    $display("[TB] special cases, issued back to back");
    applyStimulus(F3_DIVU,   32'd5,          32'd0,         5'd13, 0);
    applyStimulus(F3_REMU,   32'd5,          32'd0,         5'd14, 0);
    applyStimulus(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 0);
    applyStimulus(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 0);
    applyStimulus(F3_DIV,    32'h8000_0000,  32'd1,         5'd17, 0);

    $display("[TB] start held during CALC, and rd=0");
    applyStimulus(F3_MUL,    32'd1234,       32'd5678,      5'd18, 12);
    applyStimulus(F3_DIV,    32'hFFFF_FC00,  32'd3,         5'd0,  0);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd19, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst-busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst-done", 32'(bus.done), 32'd0);
    checkOutput("midrst-we", 32'(bus.we), 32'd0);
    checkOutput("midrst-result", bus.result, 32'd0);
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(F3_MUL, 32'd3, 32'd4, 5'd20, 0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom), pickVal(), pickVal(), 5'($urandom), 0);
    end

    waitCnt = 0;
    while ((sbQ.size() != 0 || bus.busy) && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (sbQ.size() != 0 || bus.busy) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL drain-timeout: %0d results outstanding, expected 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
